serial_fulladder_seq: RTL and testbench

//   Bit-serial N-bit adder built around one full-adder cell. Captures two

---
 rtl/serial_fulladder_seq.sv | 122 ++++++++++++
 tb/tb_serial_fulladder_seq.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/serial_fulladder_seq.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, operands shifted LSB first,
// with the carry held in a flip-flop between bits.
module serial_fulladder_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             c_out
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, psum, psum_nxt;
  logic             carry;
  logic [CW-1:0]    count;
  logic             s, cy;
  logic             load, finish;

  // The cell's operands come straight from flops, so they never glitch.
  assign fa_a = a_sr[0];
  assign fa_b = b_sr[0];
  assign fa_c = carry;

  assign s  = fa_a ^ fa_b ^ fa_c;
  assign cy = (fa_a & fa_b) | (fa_c & (fa_a ^ fa_b));

  generate
    if (WIDTH == 1) begin : g_psum_1
      assign psum_nxt = s;
    end else begin : g_psum_n
      assign psum_nxt = {s, psum[WIDTH-1:1]};
    end
  endgenerate

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    finish    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (count == LAST_BIT) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr    <= '0;
      b_sr    <= '0;
      psum    <= '0;
      carry   <= 1'b0;
      count   <= '0;
      sum_out <= '0;
      c_out   <= 1'b0;
    end else begin
      if (load) begin
        a_sr  <= a_in;
        b_sr  <= b_in;
        psum  <= '0;
        carry <= c_in;
        count <= '0;
      end else if (state == RUN) begin
        a_sr  <= a_sr >> 1;
        b_sr  <= b_sr >> 1;
        psum  <= psum_nxt;
        carry <= cy;
        count <= count + 1'b1;
      end
      // Results move only on the completion edge and hold through later runs.
      if (finish) begin
        sum_out <= psum_nxt;
        c_out   <= cy;
      end
    end
  end

endmodule

// File: tb/tb_serial_fulladder_seq.sv
// Directed bench for serial_fulladder_seq: an 8-bit instance for the
// arithmetic/timing scenarios and a 1-bit instance for the cell truth table.
module tb_serial_fulladder_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a_in, b_in;
  logic       c_in;
  logic       fa_a, fa_b, fa_c, busy, done, c_out;
  logic [7:0] sum_out;

  logic       start1, a1, b1, c1;
  logic       fa_a1, fa_b1, fa_c1, busy1, done1, c_out1;
  logic [0:0] sum1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_fulladder_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .c_in(c_in),
    .fa_a(fa_a), .fa_b(fa_b), .fa_c(fa_c), .busy(busy), .done(done),
    .sum_out(sum_out), .c_out(c_out)
  );

  serial_fulladder_seq #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a_in(a1), .b_in(b1), .c_in(c1),
    .fa_a(fa_a1), .fa_b(fa_b1), .fa_c(fa_c1), .busy(busy1), .done(done1),
    .sum_out(sum1), .c_out(c_out1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and return at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic c);
    a_in  = a;
    b_in  = b;
    c_in  = c;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  logic [1:0] exp_tt [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
  logic       seen_done;

  initial begin
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; c_in = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
    step();
    step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum_out, 8'h00);
    check("rst_cout", c_out, 0);
    check("rst_fa", {fa_a, fa_b, fa_c}, 3'b000);
    rst = 1'b0;
    step();

    // 5A + 33 with an ignored start pulse during cycle 3.
    launch(8'h5A, 8'h33, 1'b0);
    check("t1_busy_c1", busy, 1);
    check("t1_fa_bit0", {fa_a, fa_b, fa_c}, 3'b010);
    for (int k = 1; k <= 7; k++) begin
      if (k == 2) begin
        a_in = 8'h00; b_in = 8'h00; start = 1'b1;
      end else begin
        start = 1'b0; a_in = 8'hA5; b_in = 8'hC3; c_in = 1'b1;
      end
      step();
      check($sformatf("t1_busy_e%0d", k), busy, 1);
      check($sformatf("t1_done_e%0d", k), done, 0);
    end
    start = 1'b0;
    step();
    check("t1_done", done, 1);
    check("t1_busy_done", busy, 0);
    check("t1_sum", sum_out, 8'h8D);
    check("t1_cout", c_out, 0);

    // Back-to-back: start issued in the DONE cycle.
    launch(8'h01, 8'h02, 1'b1);
    check("t4_busy", busy, 1);
    check("t4_done_low", done, 0);
    check("t4_sum_hold0", sum_out, 8'h8D);
    for (int k = 0; k < 7; k++) step();
    check("t4_sum_hold7", sum_out, 8'h8D);
    check("t4_done_early", done, 0);
    step();
    check("t4_done", done, 1);
    check("t4_sum", sum_out, 8'h04);
    check("t4_cout", c_out, 0);
    step();
    check("t4_idle_done", done, 0);
    check("t4_idle_busy", busy, 0);

    // Carry propagation.
    launch(8'hFF, 8'h01, 1'b0);
    for (int k = 0; k < 7; k++) step();
    step();
    check("t2a_done", done, 1);
    check("t2a_sum", sum_out, 8'h00);
    check("t2a_cout", c_out, 1);
    step();
    launch(8'hFF, 8'hFF, 1'b1);
    for (int k = 0; k < 8; k++) step();
    check("t2b_done", done, 1);
    check("t2b_sum", sum_out, 8'hFF);
    check("t2b_cout", c_out, 1);
    step();

    // Asynchronous reset in the middle of a run.
    launch(8'h5A, 8'h33, 1'b0);
    step(); step(); step();
    #2 rst = 1'b1;
    #1;
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_sum", sum_out, 8'h00);
    check("t5_cout", c_out, 0);
    check("t5_fa", {fa_a, fa_b, fa_c}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      seen_done = seen_done | done | busy;
    end
    check("t5_no_activity", seen_done, 0);

    // WIDTH=1 truth table.
    for (int i = 0; i < 8; i++) begin
      a1 = i[2]; b1 = i[1]; c1 = i[0];
      start1 = 1'b1;
      step();
      start1 = 1'b0;
      check($sformatf("t6_fa_%0d", i), {fa_a1, fa_b1, fa_c1}, i[2:0]);
      check($sformatf("t6_busy_%0d", i), busy1, 1);
      step();
      check($sformatf("t6_done_%0d", i), done1, 1);
      check($sformatf("t6_res_%0d", i), {c_out1, sum1}, exp_tt[i]);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
